// File: rtl/err_watchdog_if.sv
// Bus between the processor-side stimulus and the watchdog monitor.
// The master drives retire activity and error flags; the slave reports the fault status.
interface err_watchdog_if #(
  parameter int NSRC = 4,
  parameter int CW   = 32
);
  logic            commit;
  logic            halt;
  logic [NSRC-1:0] err_src;
  logic            err;
  logic [2:0]      err_code;
  logic [NSRC-1:0] err_vec;
  logic            halted;
  logic [CW-1:0]   cycles;

  modport master (
    output commit, halt, err_src,
    input  err, err_code, err_vec, halted, cycles
  );

  modport slave (
    input  commit, halt, err_src,
    output err, err_code, err_vec, halted, cycles
  );
endinterface

// File: rtl/err_watchdog.sv
// Processor run monitor: latches the first fault (error flag, commit timeout,
// cycle limit or activity after halt) and holds err until reset.
module err_watchdog #(
  parameter int NSRC       = 4,
  parameter int TIMEOUT    = 1000,
  parameter int MAX_CYCLES = 100000,
  parameter int CW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  err_watchdog_if.slave bus
);
  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_SRC  = 3'd1;
  localparam logic [2:0] CODE_IDLE = 3'd2;
  localparam logic [2:0] CODE_MAX  = 3'd3;
  localparam logic [2:0] CODE_HALT = 3'd4;

  // Values are only used when the matching limit is non-zero.
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX_LAST     = CW'(MAX_CYCLES - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cycles_reg, cycles_next;
  logic [CW-1:0]   idle_reg, idle_next;
  logic [2:0]      code_reg, code_next;
  logic [NSRC-1:0] vec_reg, vec_next;
  logic            err_reg, halted_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RUN;
      cycles_reg <= '0;
      idle_reg   <= '0;
      code_reg   <= CODE_NONE;
      vec_reg    <= '0;
      err_reg    <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cycles_reg <= cycles_next;
      idle_reg   <= idle_next;
      code_reg   <= code_next;
      vec_reg    <= vec_next;
      err_reg    <= (state_next == FAULT);
      halted_reg <= (state_next == HALTED);
    end
  end

  always_comb begin
    state_next  = state_reg;
    cycles_next = cycles_reg;
    idle_next   = idle_reg;
    code_next   = code_reg;
    vec_next    = vec_reg;

    case (state_reg)
      RUN: begin
        // Both counters saturate, so the limit compares can never be skipped by a wrap.
        cycles_next = (cycles_reg == '1) ? cycles_reg : cycles_reg + 1'b1;
        if (bus.commit)
          idle_next = '0;
        else
          idle_next = (idle_reg == '1) ? idle_reg : idle_reg + 1'b1;

        if (bus.err_src != '0) begin
          state_next = FAULT;
          code_next  = CODE_SRC;
          vec_next   = bus.err_src;
        end else if (TIMEOUT != 0 && !bus.commit && idle_reg == TIMEOUT_LAST) begin
          state_next = FAULT;
          code_next  = CODE_IDLE;
        end else if (MAX_CYCLES != 0 && cycles_reg == MAX_LAST) begin
          state_next = FAULT;
          code_next  = CODE_MAX;
        end else if (bus.halt) begin
          state_next = HALTED;
        end
      end

      HALTED: begin
        if (bus.err_src != '0) begin
          state_next = FAULT;
          code_next  = CODE_SRC;
          vec_next   = bus.err_src;
        end else if (bus.commit || bus.halt) begin
          state_next = FAULT;
          code_next  = CODE_HALT;
        end
      end

      default: state_next = FAULT;
    endcase
  end

  assign bus.err      = err_reg;
  assign bus.err_code = code_reg;
  assign bus.err_vec  = vec_reg;
  assign bus.halted   = halted_reg;
  assign bus.cycles   = cycles_reg;
endmodule

// File: tb/tb_err_watchdog.sv
// Directed bench for err_watchdog: four instances cover default limits,
// a short commit timeout, a short cycle limit, and simultaneous limits.
module tb_err_watchdog;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  err_watchdog_if #(.NSRC(4), .CW(32)) if_a ();
  err_watchdog_if #(.NSRC(4), .CW(32)) if_t ();
  err_watchdog_if #(.NSRC(4), .CW(32)) if_m ();
  err_watchdog_if #(.NSRC(4), .CW(32)) if_p ();

  err_watchdog #(.NSRC(4), .TIMEOUT(1000), .MAX_CYCLES(100000), .CW(32))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  err_watchdog #(.NSRC(4), .TIMEOUT(8), .MAX_CYCLES(0), .CW(32))
    dut_t (.clk(clk), .rst(rst), .bus(if_t.slave));
  err_watchdog #(.NSRC(4), .TIMEOUT(0), .MAX_CYCLES(20), .CW(32))
    dut_m (.clk(clk), .rst(rst), .bus(if_m.slave));
  err_watchdog #(.NSRC(4), .TIMEOUT(20), .MAX_CYCLES(20), .CW(32))
    dut_p (.clk(clk), .rst(rst), .bus(if_p.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n edges; inputs and samples sit 1ns after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    if_a.commit = 0; if_a.halt = 0; if_a.err_src = '0;
    if_t.commit = 0; if_t.halt = 0; if_t.err_src = '0;
    if_m.commit = 0; if_m.halt = 0; if_m.err_src = '0;
    if_p.commit = 0; if_p.halt = 0; if_p.err_src = '0;

    // Reset state and plain commit counting
    do_reset();
    chk("rst_err", 32'(if_a.err), 32'd0);
    chk("rst_code", 32'(if_a.err_code), 32'd0);
    chk("rst_vec", 32'(if_a.err_vec), 32'd0);
    chk("rst_halted", 32'(if_a.halted), 32'd0);
    chk("rst_cycles", if_a.cycles, 32'd0);
    if_a.commit = 1;
    step(10);
    chk("run10_err", 32'(if_a.err), 32'd0);
    chk("run10_cycles", if_a.cycles, 32'd10);
    chk("run10_halted", 32'(if_a.halted), 32'd0);
    chk("run10_code", 32'(if_a.err_code), 32'd0);
    $display("txn run10: cycles=%0d err=%0b", if_a.cycles, if_a.err);

    // Source flag for one cycle at cycle 5
    do_reset();
    step(5);
    chk("src_pre_cycles", if_a.cycles, 32'd5);
    if_a.err_src = 4'b0100;
    step(1);
    if_a.err_src = '0;
    chk("src_err", 32'(if_a.err), 32'd1);
    chk("src_code", 32'(if_a.err_code), 32'd1);
    chk("src_vec", 32'(if_a.err_vec), 32'h4);
    chk("src_cycles", if_a.cycles, 32'd6);
    step(3);
    chk("src_vec_hold", 32'(if_a.err_vec), 32'h4);
    chk("src_cycles_hold", if_a.cycles, 32'd6);
    chk("src_err_hold", 32'(if_a.err), 32'd1);
    $display("txn src: code=%0d vec=%b cycles=%0d", if_a.err_code, if_a.err_vec, if_a.cycles);

    // Halt with commit at cycle 3, then activity after halt
    do_reset();
    step(3);
    if_a.halt = 1;
    step(1);
    if_a.halt = 0;
    if_a.commit = 0;
    chk("halt_halted", 32'(if_a.halted), 32'd1);
    chk("halt_cycles", if_a.cycles, 32'd4);
    chk("halt_err", 32'(if_a.err), 32'd0);
    step(1);
    chk("halt_hold", 32'(if_a.halted), 32'd1);
    chk("halt_frozen", if_a.cycles, 32'd4);
    if_a.commit = 1;
    step(1);
    if_a.commit = 0;
    chk("post_halt_err", 32'(if_a.err), 32'd1);
    chk("post_halt_code", 32'(if_a.err_code), 32'd4);
    chk("post_halt_halted", 32'(if_a.halted), 32'd0);
    chk("post_halt_vec", 32'(if_a.err_vec), 32'd0);
    $display("txn halt: code=%0d cycles=%0d", if_a.err_code, if_a.cycles);

    // Reset out of FAULT, then counting resumes
    rst = 1'b1;
    step(1);
    chk("rfault_err", 32'(if_a.err), 32'd0);
    chk("rfault_code", 32'(if_a.err_code), 32'd0);
    chk("rfault_cycles", if_a.cycles, 32'd0);
    rst = 1'b0;
    if_a.commit = 1;
    step(2);
    chk("resume_cycles", if_a.cycles, 32'd2);
    chk("resume_err", 32'(if_a.err), 32'd0);
    if_a.commit = 0;
    $display("txn reset_from_fault: cycles=%0d", if_a.cycles);

    // Commit timeout of 8
    do_reset();
    step(7);
    chk("to_pre_err", 32'(if_t.err), 32'd0);
    step(1);
    chk("to_err", 32'(if_t.err), 32'd1);
    chk("to_code", 32'(if_t.err_code), 32'd2);
    chk("to_cycles", if_t.cycles, 32'd8);
    chk("to_vec", 32'(if_t.err_vec), 32'd0);
    do_reset();
    step(5);
    if_t.commit = 1;
    step(1);
    if_t.commit = 0;
    step(7);
    chk("to_restart_pre", 32'(if_t.err), 32'd0);
    step(1);
    chk("to_restart_err", 32'(if_t.err), 32'd1);
    chk("to_restart_cycles", if_t.cycles, 32'd14);
    $display("txn timeout: code=%0d cycles=%0d", if_t.err_code, if_t.cycles);

    // Cycle limit of 20 with steady commits
    do_reset();
    if_m.commit = 1;
    step(19);
    chk("max_pre_err", 32'(if_m.err), 32'd0);
    chk("max_pre_cycles", if_m.cycles, 32'd19);
    step(1);
    chk("max_err", 32'(if_m.err), 32'd1);
    chk("max_code", 32'(if_m.err_code), 32'd3);
    chk("max_cycles", if_m.cycles, 32'd20);
    step(2);
    chk("max_frozen", if_m.cycles, 32'd20);
    if_m.commit = 0;
    $display("txn cycle_limit: code=%0d cycles=%0d", if_m.err_code, if_m.cycles);

    // Timeout and limit on the same edge, then with a source flag too
    do_reset();
    step(20);
    chk("tie_code", 32'(if_p.err_code), 32'd2);
    chk("tie_cycles", if_p.cycles, 32'd20);
    do_reset();
    step(19);
    chk("tie2_pre_err", 32'(if_p.err), 32'd0);
    if_p.err_src = 4'b0010;
    step(1);
    if_p.err_src = '0;
    chk("tie2_code", 32'(if_p.err_code), 32'd1);
    chk("tie2_vec", 32'(if_p.err_vec), 32'h2);
    $display("txn priority: code=%0d vec=%b", if_p.err_code, if_p.err_vec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
